// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per clock over N cycles.
// product is {carry, N+N-bit product} and only updates when an operation completes.
module shift_add_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   multiplicand,
  input  logic           start,
  output logic [2*N:0]   product,
  output logic           done
);

  localparam int unsigned CntW = $clog2(N + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    m_q, m_d;
  logic            c_q, c_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N:0]    product_q, product_d;
  logic            done_q, done_d;
  logic [N:0]      sum;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    c_d       = c_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = done_q;
    // c_q is always zero at the start of a step, so this is the plain A + M sum.
    sum       = q_q[0] ? ({c_q, a_q} + {1'b0, m_q}) : {c_q, a_q};

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = CntW'(N);
          done_d  = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        c_d   = 1'b0;
        a_d   = sum[N:1];
        q_d   = {sum[0], q_q[N-1:1]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          product_d = {1'b0, sum, q_q[N-1:1]};
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      c_q       <= c_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed table, corner sequences and
// random operations checked against an arithmetic reference.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] multiplier;
  logic [3:0] multiplicand;
  logic       start;
  logic [8:0] product;
  logic       done;

  int vectors = 0;
  int fails   = 0;
  logic [8:0] model_product = '0;

  typedef struct {
    logic [3:0] mr;
    logic [3:0] md;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[6];

  shift_add_multiplier #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .multiplier  (multiplier),
    .multiplicand(multiplicand),
    .start       (start),
    .product     (product),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Runs one operation starting from a negedge; checks exact latency and that product
  // holds its previous value until completion. scramble pokes inputs during CALC.
  task automatic run_op(input logic [3:0] mr, input logic [3:0] md, input logic [8:0] exp,
                        input bit scramble);
    multiplier   = mr;
    multiplicand = md;
    start        = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble && e < 4) begin
        multiplier   = 4'($urandom);
        multiplicand = 4'($urandom);
        start        = (e == 2);
      end
      check($sformatf("done_after_edge%0d", e), {8'b0, done}, {8'b0, (e == 5)});
      if (e < 5) check("product_hold_calc", product, model_product);
    end
    model_product = exp;
    check($sformatf("product_%0dx%0d", mr, md), product, exp);
  endtask

  initial begin
    tbl[0] = '{4'd15, 4'd15, 9'd225};
    tbl[1] = '{4'd0,  4'd9,  9'd0};
    tbl[2] = '{4'd1,  4'd15, 9'd15};
    tbl[3] = '{4'd15, 4'd1,  9'd15};
    tbl[4] = '{4'd7,  4'd9,  9'd63};
    tbl[5] = '{4'd9,  4'd0,  9'd0};

    rst = 1'b1; start = 1'b0; multiplier = '0; multiplicand = '0;
    repeat (2) @(negedge clk);
    check("reset_done", {8'b0, done}, 9'd0);
    check("reset_product", product, 9'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {8'b0, done}, 9'd0);

    for (int i = 0; i < 6; i++) run_op(tbl[i].mr, tbl[i].md, tbl[i].exp, 1'b0);

    // Abort mid-CALC with an asynchronous reset, then a fresh run.
    run_op(4'd15, 4'd15, 9'd225, 1'b0);
    multiplier = 4'd13; multiplicand = 4'd11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_done", {8'b0, done}, 9'd0);
    check("async_rst_product", product, 9'd0);
    model_product = '0;
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_abort_done", {8'b0, done}, 9'd0);
    check("idle_after_abort_product", product, 9'd0);
    run_op(4'd15, 4'd15, 9'd225, 1'b0);

    // Inputs and start changes during CALC are ignored; result then holds.
    run_op(4'd3, 4'd5, 9'd15, 1'b1);
    multiplier = 4'd12; multiplicand = 4'd10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_done", {8'b0, done}, 9'd1);
      check("hold_product", product, 9'd15);
    end

    // Start held high: done pulses once every five edges.
    multiplier = 4'd2; multiplicand = 4'd3; start = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      check($sformatf("held_start_done_edge%0d", e), {8'b0, done}, {8'b0, (e % 5 == 0)});
      if (e % 5 == 0) check("held_start_product", product, 9'd6);
    end
    start = 1'b0;
    model_product = 9'd6;

    for (int i = 0; i < 40; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      run_op(a, b, 9'(int'(a) * int'(b)), (i % 4 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: N, default 4, operand width; product width SHALL be 2N+1; all widths below are for N=4.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 multiplier  input  4  unsigned operand; SHALL be sampled only when start is captured.
REQ-005 multiplicand  input  4  unsigned operand; SHALL be sampled only when start is captured.
REQ-006 start  input  1  request; level-sampled on the rising edge; a single-cycle pulse SHALL suffice.
REQ-007 product  output  9  registered result: bit 8 is the carry bit, bits 7:0 are the unsigned 8-bit product.
REQ-008 done  output  1  registered; high while the FSM is in DONE.

Function
REQ-009 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-010 Internal registers: M (4-bit multiplicand), C (1-bit carry), A (4-bit accumulator), Q (4-bit multiplier), cnt (counts N down to 0).
REQ-011 IDLE or DONE with start=1 at an edge SHALL do the following:
- load M=multiplicand, Q=multiplier, A=0, C=0, cnt=N;
- go to CALC;
- clear done.
REQ-012 Each CALC cycle SHALL perform one add-and-shift step:
- if Q[0]=1, form {C,A} = A + M (5-bit sum), else {C,A} = {0,A};
- then shift {C,A,Q} right by one, filling the MSB with 0;
- decrement cnt.
REQ-013 After the N-th CALC step the FSM SHALL go to DONE.
- On that same edge: product = {C,A,Q} after the step, and done = 1.
REQ-014 Latency: done SHALL be high after exactly N+1 = 5 rising edges, counting the edge that captures start as edge 1.
REQ-015 At completion product[8] SHALL be 0 and product[7:0] SHALL equal multiplier*multiplicand.
REQ-016 product SHALL hold its last value until the next completion or reset.
- It SHALL NOT show intermediate CALC values.
REQ-017 DONE SHALL persist (done=1, product stable) until start=1 is captured; that capture starts a new operation per REQ-011.
REQ-018 start and operand changes during CALC SHALL be ignored; an operation SHALL always run all N steps.
REQ-019 start held high continuously SHALL start a new operation on the first edge in DONE.
- Result: done is high for exactly one cycle per operation.
REQ-020 A zero operand SHALL still take the full latency and yield product = 0.

Reset
REQ-021 rst=1 SHALL asynchronously force the following, regardless of clk: FSM=IDLE, done=0, product=0, and M, C, A, Q, cnt = 0.
REQ-022 Reset mid-CALC SHALL abort the operation; no partial result SHALL appear on product.
REQ-023 After rst deasserts, the block SHALL be idle until start is captured.

Verification
REQ-024 rst pulse, then multiplier=15, multiplicand=15, one-cycle start pulse:
- done rises on the 5th edge;
- product = 9'b0_1110_0001 (225).
REQ-025 multiplier=0, multiplicand=9 -> product=0 with done after 5 edges; also 1 x 15 -> 15, and 15 x 1 -> 15.
REQ-026 Assert rst during the 3rd CALC cycle -> done=0 and product=0 immediately (asynchronously), FSM in IDLE.
- A fresh 15 x 15 afterwards -> 225.
REQ-027 Start 3 x 5, toggle operands and pulse start during CALC:
- changes are ignored; product = 15 after 5 edges;
- product stays 15 and done stays 1 for 20 idle cycles.
REQ-028 Back-to-back runs:
- from DONE (15 x 15 = 225), capture start with 7 x 9 -> done drops next edge, product stays 225 until completion, then 63;
- start held high -> done pulses one cycle every 5 edges.
